// File: rtl/seq_gen_moore_if.sv
// Control and serial-output bundle of the pattern transmitter.
// The master side (stimulus or host) drives the controls. The slave side (the transmitter) drives the serial stream and status.
interface seq_gen_moore_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             abort;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [CNT_W-1:0] gap_len;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] reps_left;

  modport master (
    output en, abort, start, pattern, repeat_cnt, gap_len,
    input  x, x_valid, busy, done, reps_left
  );

  modport slave (
    input  en, abort, start, pattern, repeat_cnt, gap_len,
    output x, x_valid, busy, done, reps_left
  );
endinterface

// File: rtl/seq_gen_moore.sv
// Serial pattern transmitter. It sends a latched pattern MSB first, repeats it, and can insert zero-gap bits between repetitions.
// All outputs are registered and decoded from the next state, so no input reaches an output combinationally.
module seq_gen_moore #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_gen_moore_if.slave bus
);
  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] reps_left_q, reps_left_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] gap_ctr_q, gap_ctr_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every _d starts as its _q, so any path that does not assign a value simply holds it (en=0 included) and no latch is inferred.
    state_d     = state_q;
    shreg_d     = shreg_q;
    pat_d       = pat_q;
    bit_cnt_d   = bit_cnt_q;
    reps_left_d = reps_left_q;
    gap_len_d   = gap_len_q;
    gap_ctr_d   = gap_ctr_q;

    if (bus.abort) begin
      state_d     = IDLE;
      shreg_d     = '0;
      pat_d       = '0;
      bit_cnt_d   = '0;
      reps_left_d = '0;
      gap_len_d   = '0;
      gap_ctr_d   = '0;
    end else if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            pat_d     = bus.pattern;
            gap_len_d = bus.gap_len;
            if (bus.repeat_cnt == '0) begin
              state_d     = DONE;
              reps_left_d = '0;
            end else begin
              state_d     = SHIFT;
              shreg_d     = bus.pattern;
              bit_cnt_d   = BIT_LAST;
              reps_left_d = bus.repeat_cnt - CNT_W'(1);
            end
          end
        end
        SHIFT: begin
          if (bit_cnt_q != '0) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - BW'(1);
          end else if (reps_left_q == '0) begin
            state_d = DONE;
            shreg_d = '0;
          end else if (gap_len_q != '0) begin
            state_d   = GAP;
            shreg_d   = '0;
            gap_ctr_d = gap_len_q - CNT_W'(1);
          end else begin
            // Back-to-back repetition: reload without a bubble cycle.
            shreg_d     = pat_q;
            bit_cnt_d   = BIT_LAST;
            reps_left_d = reps_left_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_ctr_q == '0) begin
            state_d     = SHIFT;
            shreg_d     = pat_q;
            bit_cnt_d   = BIT_LAST;
            reps_left_d = reps_left_q - CNT_W'(1);
          end else begin
            gap_ctr_d = gap_ctr_q - CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    x_d       = (state_d == SHIFT) && shreg_d[PAT_W-1];
    x_valid_d = (state_d == SHIFT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only; the combinational block above uses blocking ones.
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      reps_left_q <= '0;
      gap_len_q   <= '0;
      gap_ctr_q   <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      pat_q       <= pat_d;
      bit_cnt_q   <= bit_cnt_d;
      reps_left_q <= reps_left_d;
      gap_len_q   <= gap_len_d;
      gap_ctr_q   <= gap_ctr_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.x_valid   = x_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reps_left = reps_left_q;
endmodule
